// File: rtl/rv32i_pkg.sv
// RV32I base opcodes and the instruction-format codes carried on tipo_out.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [2:0] TIPO_R    = 3'd0;
  localparam logic [2:0] TIPO_I    = 3'd1;
  localparam logic [2:0] TIPO_S    = 3'd2;
  localparam logic [2:0] TIPO_B    = 3'd3;
  localparam logic [2:0] TIPO_U    = 3'd4;
  localparam logic [2:0] TIPO_J    = 3'd5;
  localparam logic [2:0] TIPO_NONE = 3'd7;

endpackage

// File: rtl/gen_inmediato.sv
// Combinational RV32I immediate builder: reassembles the scattered immediate
// bits of instr[31:7] for the given format; R and NONE give zero.
module gen_inmediato
  import rv32i_pkg::*;
(
  input  logic [31:7] instr,
  input  logic [2:0]  tipo,
  output logic [31:0] imm
);

  always_comb begin
    imm = 32'd0;
    case (tipo)
      TIPO_I: imm = {{20{instr[31]}}, instr[31:20]};
      TIPO_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      TIPO_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      TIPO_U: imm = {instr[31:12], 12'd0};
      TIPO_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/etapa_decodificacion.sv
// RV32I decode stage: drives register-file read ports in the accept cycle and
// registers decoded fields so they line up with the register file's data.
module etapa_decodificacion
  import rv32i_pkg::*;
#(
  parameter int ANCHO_XLEN = 32
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [31:0]           instr_in,
  input  logic [ANCHO_XLEN-1:0] pc_in,
  output logic                  hab_r1,
  output logic [4:0]            addr_r1,
  output logic                  hab_r2,
  output logic [4:0]            addr_r2,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [ANCHO_XLEN-1:0] pc_out,
  output logic [4:0]            rd_out,
  output logic                  hab_w_out,
  output logic [ANCHO_XLEN-1:0] imm_out,
  output logic [6:0]            opcode_out,
  output logic [2:0]            funct3_out,
  output logic                  funct7b5_out,
  output logic [2:0]            tipo_out,
  output logic                  illegal_out
);

  logic                  r_vld_p1;
  logic [ANCHO_XLEN-1:0] r_pc_p1;
  logic [4:0]            r_rd_p1;
  logic                  r_hab_w_p1;
  logic [ANCHO_XLEN-1:0] r_imm_p1;
  logic [6:0]            r_opcode_p1;
  logic [2:0]            r_funct3_p1;
  logic                  r_funct7b5_p1;
  logic [2:0]            r_tipo_p1;
  logic                  r_illegal_p1;

  logic                  w_accept;
  logic [6:0]            w_opcode;
  logic [4:0]            w_rd;
  logic [2:0]            w_tipo;
  logic                  w_illegal;
  logic                  w_uses_rs1;
  logic                  w_uses_rs2;
  logic                  w_writes_rd;
  logic [31:0]           w_imm;

  assign w_opcode = instr_in[6:0];
  assign w_rd     = instr_in[11:7];

  // Full 7-bit match also enforces instr[1:0] == 2'b11.
  always_comb begin
    w_tipo      = TIPO_NONE;
    w_illegal   = 1'b0;
    w_uses_rs1  = 1'b0;
    w_uses_rs2  = 1'b0;
    w_writes_rd = 1'b0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_tipo      = TIPO_U;
        w_writes_rd = 1'b1;
      end
      OPC_JAL: begin
        w_tipo      = TIPO_J;
        w_writes_rd = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        w_tipo      = TIPO_I;
        w_uses_rs1  = 1'b1;
        w_writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        w_tipo     = TIPO_B;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OPC_STORE: begin
        w_tipo     = TIPO_S;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        w_tipo      = TIPO_R;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
        w_writes_rd = 1'b1;
      end
      OPC_MISCMEM, OPC_SYSTEM: w_tipo = TIPO_NONE;
      default: w_illegal = 1'b1;
    endcase
  end

  gen_inmediato u_gen_inmediato (
    .instr (instr_in[31:7]),
    .tipo  (w_tipo),
    .imm   (w_imm)
  );

  assign ready_out = !r_vld_p1 || ready_in;
  assign w_accept  = valid_in && ready_out && !flush && !rst;
  assign addr_r1   = instr_in[19:15];
  assign addr_r2   = instr_in[24:20];
  assign hab_r1    = w_accept && w_uses_rs1;
  assign hab_r2    = w_accept && w_uses_rs2;

  // Stage p0 -> p1: decoded fields register alongside the register-file read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1      <= 1'b0;
      r_pc_p1       <= '0;
      r_rd_p1       <= 5'd0;
      r_hab_w_p1    <= 1'b0;
      r_imm_p1      <= '0;
      r_opcode_p1   <= 7'd0;
      r_funct3_p1   <= 3'd0;
      r_funct7b5_p1 <= 1'b0;
      r_tipo_p1     <= 3'd0;
      r_illegal_p1  <= 1'b0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1      <= 1'b1;
      r_pc_p1       <= pc_in;
      r_rd_p1       <= w_rd;
      r_hab_w_p1    <= w_writes_rd && (w_rd != 5'd0);
      r_imm_p1      <= w_imm;
      r_opcode_p1   <= w_opcode;
      r_funct3_p1   <= instr_in[14:12];
      r_funct7b5_p1 <= instr_in[30];
      r_tipo_p1     <= w_tipo;
      r_illegal_p1  <= w_illegal;
    end else if (r_vld_p1 && ready_in) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign valid_out    = r_vld_p1;
  assign pc_out       = r_pc_p1;
  assign rd_out       = r_rd_p1;
  assign hab_w_out    = r_hab_w_p1;
  assign imm_out      = r_imm_p1;
  assign opcode_out   = r_opcode_p1;
  assign funct3_out   = r_funct3_p1;
  assign funct7b5_out = r_funct7b5_p1;
  assign tipo_out     = r_tipo_p1;
  assign illegal_out  = r_illegal_p1;

endmodule

// File: doc/etapa_decodificacion.md
Name: etapa_decodificacion

Overview:
- RV32I decode stage sitting directly upstream of conjunto_reg32x32.
- Accepts one fetched instruction per cycle over a valid/ready handshake and drives the register file read ports (hab_r1/addr_r1, hab_r2/addr_r2) in the accept cycle.
- Registers the decoded fields so they leave the stage in the same cycle the register file presents data_r1/data_r2.
- One-entry pipeline register with stall and flush.

Parameters:
- ANCHO_XLEN, 32, datapath/immediate width; fixed at 32 for RV32I.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard held and incoming instruction
- valid_in  in  1  instr_in/pc_in valid
- ready_out  out  1  stage can accept
- instr_in  in  32  instruction word
- pc_in  in  32  instruction address
- hab_r1  out  1  register file port 1 read enable
- addr_r1  out  5  rs1 index
- hab_r2  out  1  register file port 2 read enable
- addr_r2  out  5  rs2 index
- valid_out  out  1  decoded instruction valid
- ready_in  in  1  downstream accepts
- pc_out  out  32  registered pc
- rd_out  out  5  destination index
- hab_w_out  out  1  instruction writes rd (rd != 0)
- imm_out  out  32  sign-extended immediate
- opcode_out  out  7  instr[6:0]
- funct3_out  out  3  instr[14:12]
- funct7b5_out  out  1  instr[30]
- tipo_out  out  3  format: R/I/S/B/U/J/NONE
- illegal_out  out  1  unsupported encoding

Behaviour:
- ready_out = !valid_out || ready_in. accept = valid_in && ready_out && !flush && !rst.
- addr_r1 = instr_in[19:15] and addr_r2 = instr_in[24:20], always driven.
- hab_r1 = accept && uses_rs1; hab_r2 = accept && uses_rs2. Both are 0 on stall, flush or reset, so the register file holds its outputs while stalled.
- uses_rs1 opcodes: JALR, BRANCH, LOAD, STORE, OP-IMM, OP. uses_rs2 opcodes: BRANCH, STORE, OP.
- Latency 1: on the edge after accept, all outputs load and valid_out=1. data_r1/data_r2 are valid in that same cycle.
- If valid_out && ready_in && !accept, valid_out=0 next cycle; other fields hold.
- If valid_out && !ready_in, all outputs hold unchanged.
- Legal opcodes (instr[1:0] must be 11):
  - LUI/AUIPC: U
  - JAL: J
  - JALR/LOAD/OP-IMM: I
  - BRANCH: B
  - STORE: S
  - OP: R
  - MISC-MEM (FENCE): NONE, treated as NOP
  - SYSTEM: NONE
- Anything else: illegal_out=1, tipo=NONE, hab_w_out=0, imm=0, hab_r1=hab_r2=0. The instruction still passes downstream with valid_out=1.
- hab_w_out = (LUI|AUIPC|JAL|JALR|LOAD|OP-IMM|OP) && rd != 0.
- Immediates follow standard RV32I bit-scatter, sign-extended from instr[31]. U: {instr[31:12],12'b0}. R/NONE: 0.
- flush: valid_out=0 next edge; any instruction presented that cycle is dropped, with no read enables.
- rst: next edge valid_out=0, and pc_out, rd_out, hab_w_out, imm_out, opcode_out, funct3_out, funct7b5_out, tipo_out, illegal_out all become 0. hab_r1=hab_r2=0 while rst=1. rst overrides flush and accept.
- No hazard bypass: RAW hazards against writeback are resolved by stalls outside this block.

Decomposition:
- Package rv32i_pkg holds:
  - opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISCMEM, OPC_SYSTEM)
  - tipo_out encodings (TIPO_R=0, I=1, S=2, B=3, U=4, J=5, NONE=7)
- Sub-module gen_inmediato: combinational, (instr, tipo) -> imm.

Test Plan:
- ADDI x1,x2,-5 (0xFFB10093), ready_in=1 -> accept cycle: hab_r1=1, addr_r1=2, hab_r2=0. Next cycle: valid_out=1, rd_out=1, imm_out=0xFFFFFFFB, tipo=I, hab_w_out=1.
- SW x5,8(x6) (0x00532423) -> hab_r1=1, addr_r1=6, hab_r2=1, addr_r2=5. Next cycle: imm_out=8, tipo=S, hab_w_out=0.
- valid_out=1 with ready_in=0 for 3 cycles, valid_in=1 -> ready_out=0, hab_r1=hab_r2=0 and all outputs stable. ready_in=1 -> new instruction accepted that cycle.
- LUI x0,0x12345 (0x12345037) -> imm_out=0x12345000, tipo=U, hab_w_out=0 (rd=0), hab_r1=hab_r2=0.
- 0x00000000 -> illegal_out=1, valid_out=1, hab_r1=hab_r2=0, hab_w_out=0.
- flush with valid_out=1 and valid_in=1 -> no read enables that cycle, valid_out=0 next edge. rst mid-stream -> every output 0 after the edge.
